// File: rtl/step_phase_decoder.sv
// step_phase_decoder: decodes four PWM stepper coil lines into a half-step phase,
// signed step position, direction, moving flag and sticky fault.
module step_phase_decoder #(
   parameter int HOLD_CYCLES    = 300,
   parameter int SETTLE_CYCLES  = 1000,
   parameter int TIMEOUT_CYCLES = 500000,
   parameter int POS_W          = 16
) (
   input  logic             CLK,
   input  logic             rst_n,
   input  logic             INA,
   input  logic             INA2,
   input  logic             INB,
   input  logic             INB2,
   input  logic             clear_fault,
   input  logic             pos_clear,
   output logic [2:0]       phase,
   output logic             phase_valid,
   output logic             step_pulse,
   output logic             dir,
   output logic [POS_W-1:0] position,
   output logic             moving,
   output logic             fault
);
   localparam int HW = $clog2(HOLD_CYCLES + 1);
   localparam int SW = $clog2(SETTLE_CYCLES);
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   typedef enum logic {IDLE, TRACK} state_t;
   state_t r_state, w_state_nx;
   logic [3:0] r_meta, r_sync, r_prev, r_acc_pat, w_cand;
   logic [HW-1:0] r_hold [4];
   logic [SW-1:0] r_stab;
   logic [TW-1:0] r_tmo, w_tmo_nx;
   logic [2:0] w_p, w_d, w_phase_nx;
   logic [POS_W-1:0] w_pos_nx;
   logic w_accept, w_illegal, w_pv_nx, w_step_nx, w_dir_nx, w_mov_nx, w_fault_ev;
   always_ff @(posedge CLK or negedge rst_n)
      if (!rst_n) begin
         r_meta <= '0;
         r_sync <= '0;
      end else begin
         r_meta <= {INA, INA2, INB, INB2};
         r_sync <= r_meta;
      end
   // A coil stays active for HOLD_CYCLES after its last high, bridging PWM low time.
   always_ff @(posedge CLK or negedge rst_n)
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) r_hold[i] <= '0;
      end else begin
         for (int i = 0; i < 4; i++)
            r_hold[i] <= r_sync[i] ? HW'(HOLD_CYCLES) : (r_hold[i] != '0) ? r_hold[i] - 1'b1 : r_hold[i];
      end
   always_comb begin
      w_cand = '0;
      for (int i = 0; i < 4; i++) w_cand[i] = (r_hold[i] != '0);
   end
   always_ff @(posedge CLK or negedge rst_n)
      if (!rst_n) begin
         r_prev <= '0;
         r_stab <= '0;
      end else begin
         r_prev <= w_cand;
         r_stab <= (w_cand != r_prev) ? '0 : (r_stab == SW'(SETTLE_CYCLES - 1)) ? r_stab : r_stab + 1'b1;
      end
   assign w_accept  = (w_cand == r_prev) && (r_stab == SW'(SETTLE_CYCLES - 1)) && (w_cand != r_acc_pat);
   assign w_illegal = (w_cand[3] & w_cand[2]) | (w_cand[1] & w_cand[0]);
   always_comb begin
      w_p = 3'd0;
      case (w_cand)
         4'b0101: w_p = 3'd1;
         4'b0100: w_p = 3'd2;
         4'b0110: w_p = 3'd3;
         4'b0010: w_p = 3'd4;
         4'b1010: w_p = 3'd5;
         4'b1000: w_p = 3'd6;
         4'b1001: w_p = 3'd7;
         default: w_p = 3'd0;
      endcase
   end
   assign w_d = w_p - phase;
   always_comb begin
      w_state_nx = r_state;
      w_phase_nx = phase;
      w_pv_nx    = phase_valid;
      w_step_nx  = 1'b0;
      w_dir_nx   = dir;
      w_pos_nx   = position;
      w_fault_ev = 1'b0;
      w_mov_nx   = moving && (r_tmo != TW'(TIMEOUT_CYCLES - 1));
      w_tmo_nx   = w_mov_nx ? r_tmo + 1'b1 : '0;
      if (w_accept) begin
         if (w_cand == 4'b0000) begin
            w_state_nx = IDLE;
            w_pv_nx    = 1'b0;
            w_mov_nx   = 1'b0;
         end else if (w_illegal) begin
            w_state_nx = IDLE;
            w_pv_nx    = 1'b0;
            w_fault_ev = 1'b1;
         end else if (r_state == IDLE) begin
            w_state_nx = TRACK;
            w_phase_nx = w_p;
            w_pv_nx    = 1'b1;
         end else begin
            w_phase_nx = w_p;
            if (w_d == 3'd1 || w_d == 3'd7) begin
               w_pos_nx  = (w_d == 3'd1) ? position + 1'b1 : position - 1'b1;
               w_dir_nx  = (w_d == 3'd1);
               w_step_nx = 1'b1;
               w_mov_nx  = 1'b1;
               w_tmo_nx  = '0;
            end else begin
               w_fault_ev = 1'b1;
            end
         end
      end
      if (pos_clear) w_pos_nx = '0;
   end
   always_ff @(posedge CLK or negedge rst_n)
      if (!rst_n) begin
         r_state     <= IDLE;
         r_acc_pat   <= '0;
         r_tmo       <= '0;
         phase       <= '0;
         phase_valid <= 1'b0;
         step_pulse  <= 1'b0;
         dir         <= 1'b0;
         position    <= '0;
         moving      <= 1'b0;
         fault       <= 1'b0;
      end else begin
         r_state     <= w_state_nx;
         r_acc_pat   <= w_accept ? w_cand : r_acc_pat;
         r_tmo       <= w_tmo_nx;
         phase       <= w_phase_nx;
         phase_valid <= w_pv_nx;
         step_pulse  <= w_step_nx;
         dir         <= w_dir_nx;
         position    <= w_pos_nx;
         moving      <= w_mov_nx;
         fault       <= (fault & ~clear_fault) | w_fault_ev;
      end
endmodule
